select_debouncer: RTL and testbench

Upstream conditioning stage for the clock divider's 8-bit index-select line.
- Synchronises the raw switch bus `ui_in` into the `clk` domain.
- Debounces the bus as a whole word and commits a new value only after it has been stable for a programmable number of cycles.
- Drives the divider's select input with a glitch-free code, plus a one-cycle "new select" strobe that downstream stages may use to restart counting cleanly.

---
 rtl/select_debouncer_pkg.sv | 12 +
 rtl/select_debouncer_sync2.sv | 23 ++
 rtl/select_debouncer.sv | 102 ++++++++++
 tb/tb_select_debouncer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/select_debouncer_pkg.sv
// Shared types and constants for the select-line debouncer and its benches.
package select_debouncer_pkg;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/select_debouncer_sync2.sv
// Parameterised-width two-flop synchroniser, async active-low reset to 0.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/select_debouncer.sv
// Synchronises and word-debounces the divider select bus; commits a new code
// only after it has been stable for DEBOUNCE_CYCLES cycles.
module select_debouncer
  import select_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sel_out,
  output logic             sel_valid,
  output logic             sel_busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("select_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] cand, cand_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  state_t           state, state_next;
  logic             commit;
  logic [WIDTH-1:0] sel_out_d;
  logic             sel_valid_d;
  logic             sel_busy_d;

  sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_in),
    .q     (sync_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      sel_out   <= '0;
      sel_valid <= 1'b0;
      sel_busy  <= 1'b0;
    end else begin
      state     <= state_next;
      cand      <= cand_next;
      cnt       <= cnt_next;
      sel_out   <= sel_out_d;
      sel_valid <= sel_valid_d;
      sel_busy  <= sel_busy_d;
    end
  end

  // A bounce back to the committed word is taken as a new candidate first,
  // so the return to IDLE happens one cycle later without a pulse.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    commit     = 1'b0;
    if (!ena) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sync_q != sel_out) begin
            cand_next  = sync_q;
            cnt_next   = '0;
            state_next = SETTLE;
          end
        end
        SETTLE: begin
          if (sync_q != cand) begin
            cand_next = sync_q;
            cnt_next  = '0;
          end else if (cand == sel_out) begin
            state_next = IDLE;
          end else if (cnt == CNT_LAST) begin
            commit     = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    sel_out_d   = commit ? cand : sel_out;
    sel_valid_d = commit;
    sel_busy_d  = (state_next == SETTLE);
  end

endmodule

// File: tb/tb_select_debouncer.sv
// Randomised and directed bench for select_debouncer against a run-length model.
module tb_select_debouncer;
  import select_debouncer_pkg::*;

  localparam int D = SIM_DEBOUNCE_CYCLES;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] sw_in;
  logic [7:0] sel_out;
  logic       sel_valid;
  logic       sel_busy;

  int errors = 0;
  int checks = 0;

  // Reference model: values seen by the debouncer and length of the current stable run.
  logic [7:0] m_d1, m_d2, m_prev_s, m_sel;
  logic       m_valid, m_busy;
  int         m_run;

  select_debouncer #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sw_in     (sw_in),
    .sel_out   (sel_out),
    .sel_valid (sel_valid),
    .sel_busy  (sel_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_prev_s = '0; m_sel = '0;
    m_valid = 1'b0; m_busy = 1'b0; m_run = 0;
  endtask

  // A word commits once it has been seen on D+1 consecutive enabled edges.
  task automatic model_step();
    logic [7:0] s;
    logic       cm;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = m_d2; m_d2 = m_d1; m_d1 = sw_in;
    if (!ena) begin
      m_run = 0; m_valid = 1'b0; m_busy = 1'b0;
    end else begin
      m_run = (m_run > 0 && s == m_prev_s) ? m_run + 1 : 1;
      if (m_run > D + 1) m_run = D + 2;
      cm = (m_run == D + 1) && (s != m_sel);
      m_busy  = !cm && ((s != m_sel) || (m_busy && s != m_prev_s));
      m_valid = cm;
      if (cm) m_sel = s;
    end
    m_prev_s = s;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_sel_out", 32'(sel_out), 32'(m_sel));
    check("model_sel_valid", 32'(sel_valid), 32'(m_valid));
    check("model_sel_busy", 32'(sel_busy), 32'(m_busy));
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_sel_out", 32'(sel_out), 32'h0);
    check("async_rst_valid", 32'(sel_valid), 32'h0);
    check("async_rst_busy", 32'(sel_busy), 32'h0);
  endtask

  initial begin
    int n;
    int pulses;
    logic seen_busy, seen_01;
    logic [7:0] vals [5];
    vals[0] = 8'h00; vals[1] = 8'h5A; vals[2] = 8'hA5; vals[3] = 8'hFF; vals[4] = 8'h0F;

    model_reset();
    rst_n = 1'b0; ena = 1'b1; sw_in = 8'hFF;

    // Reset held with the switches high
    repeat (3) tick();
    check("reset_sel_out", 32'(sel_out), 32'h00);
    check("reset_valid", 32'(sel_valid), 32'h0);
    check("reset_busy", 32'(sel_busy), 32'h0);
    sw_in = 8'h00;
    rst_n = 1'b1;
    repeat (6) tick();

    // Clean step
    sw_in = 8'h5A;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("step_busy_e%0d", e), 32'(sel_busy), 32'((e >= 3 && e <= D + 2) ? 1 : 0));
      check($sformatf("step_valid_e%0d", e), 32'(sel_valid), 32'((e == D + 3) ? 1 : 0));
      check($sformatf("step_sel_e%0d", e), 32'(sel_out), (e >= D + 3) ? 32'h5A : 32'h00);
    end

    // Bounce between 0x01 and 0x03, then settle on 0x03
    pulses = 0; seen_01 = 1'b0;
    for (int c = 0; c < 22; c++) begin
      sw_in = (c < 10 && ((c / 2) % 2 == 0)) ? 8'h01 : 8'h03;
      tick();
      if (sel_valid) pulses++;
      if (sel_out == 8'h01) seen_01 = 1'b1;
    end
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_no_01", 32'(seen_01), 32'd0);
    check("bounce_final", 32'(sel_out), 32'h03);

    // Glitch returning to the committed word
    sw_in = 8'h00;
    repeat (10) tick();
    check("glitch_pre_sel", 32'(sel_out), 32'h00);
    pulses = 0; seen_busy = 1'b0;
    sw_in = 8'h01;
    repeat (2) begin tick(); if (sel_valid) pulses++; if (sel_busy) seen_busy = 1'b1; end
    sw_in = 8'h00;
    repeat (10) begin tick(); if (sel_valid) pulses++; if (sel_busy) seen_busy = 1'b1; end
    check("glitch_busy_seen", 32'(seen_busy), 32'd1);
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_sel", 32'(sel_out), 32'h00);
    check("glitch_idle", 32'(sel_busy), 32'd0);

    // Enable gating mid-settle
    sw_in = 8'h22;
    repeat (4) tick();
    ena = 1'b0;
    pulses = 0;
    repeat (3) begin tick(); if (sel_valid) pulses++; end
    check("ena_low_pulses", 32'(pulses), 32'd0);
    check("ena_low_sel", 32'(sel_out), 32'h00);
    ena = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sel_valid) begin n = k; break; end
    end
    check("ena_commit_edge", 32'(n), 32'(D + 1));
    check("ena_commit_sel", 32'(sel_out), 32'h22);

    // Reset mid-settle
    sw_in = 8'h7F;
    repeat (4) tick();
    async_reset_pulse();
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sel_valid) begin n = k; break; end
    end
    check("rst_commit_edge", 32'(n), 32'(D + 3));
    check("rst_commit_sel", 32'(sel_out), 32'h7F);

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 15)
        sw_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : vals[$urandom_range(0, 4)];
      ena = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 199) == 0) begin
        async_reset_pulse();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
